// File: rtl/credential_collector.sv
// rtl/credential_collector.sv - serial username/password collector; lockout enabled by CREDENTIAL_LOCKOUT_EN
module credential_collector #(
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [63:0] username,
    output logic [63:0] password,
    output logic        check,
    input  logic        match_in,
    output logic        granted,
    output logic        denied,
    output logic        overflow,
    output logic        locked
);

    if ((MAX_FAILS < 1) || (MAX_FAILS > 15) || (LOCK_CYCLES < 1) || (LOCK_CYCLES > 65535)) begin : g_bad_params
        $error("credential_collector: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_USER   = 3'd0,
        S_PASS   = 3'd1,
        S_CHECK  = 3'd2,
        S_RESULT = 3'd3
`ifdef CREDENTIAL_LOCKOUT_EN
        ,
        S_LOCKED = 3'd4
`endif
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] field_cnt;
    logic       match_q;
    logic       accept;
    logic       is_nul;

    assign accept = char_valid && char_ready;
    assign is_nul = (char_in == 8'h00);

`ifdef CREDENTIAL_LOCKOUT_EN
    logic [3:0]  fail_cnt;
    logic [3:0]  fail_inc;
    logic [15:0] lock_timer;
    logic        lock_now;

    assign fail_inc = (fail_cnt == 4'd15) ? 4'd15 : fail_cnt + 4'd1;
    assign lock_now = denied && (fail_inc == 4'(MAX_FAILS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_cnt   <= 4'd0;
            lock_timer <= 16'd0;
        end else if (state == S_RESULT) begin
            if (granted) begin
                fail_cnt <= 4'd0;
            end else begin
                fail_cnt <= fail_inc;
            end
            if (lock_now) begin
                lock_timer <= 16'(LOCK_CYCLES - 1);
            end
        end else if (state == S_LOCKED) begin
            // timer counts down to zero inclusive, giving LOCK_CYCLES cycles in LOCKED
            if (lock_timer == 16'd0) begin
                fail_cnt <= 4'd0;
            end else begin
                lock_timer <= lock_timer - 16'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_USER;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_USER:   if (accept && is_nul) state_next = S_PASS;
            S_PASS:   if (accept && is_nul) state_next = S_CHECK;
            S_CHECK:  state_next = S_RESULT;
`ifdef CREDENTIAL_LOCKOUT_EN
            S_RESULT: state_next = lock_now ? S_LOCKED : S_USER;
            S_LOCKED: if (lock_timer == 16'd0) state_next = S_USER;
`else
            S_RESULT: state_next = S_USER;
`endif
            default:  state_next = S_USER;
        endcase
    end

    always_comb begin
        char_ready = (state == S_USER) || (state == S_PASS);
        check      = (state == S_CHECK);
        granted    = (state == S_RESULT) && match_q && !overflow;
        denied     = (state == S_RESULT) && !(match_q && !overflow);
        locked     = 1'b0;
`ifdef CREDENTIAL_LOCKOUT_EN
        locked     = (state == S_LOCKED);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_q <= 1'b0;
        end else if (state == S_CHECK) begin
            match_q <= match_in;
        end
    end

    // field_cnt saturates at 8; any further non-NUL character only flags overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            username  <= 64'd0;
            password  <= 64'd0;
            overflow  <= 1'b0;
            field_cnt <= 4'd0;
        end else if (state == S_RESULT) begin
            username  <= 64'd0;
            password  <= 64'd0;
            overflow  <= 1'b0;
            field_cnt <= 4'd0;
        end else if (accept) begin
            if (is_nul) begin
                field_cnt <= 4'd0;
            end else if (field_cnt[3]) begin
                overflow <= 1'b1;
            end else begin
                if (state == S_USER) begin
                    username[{field_cnt[2:0], 3'b000} +: 8] <= char_in;
                end else begin
                    password[{field_cnt[2:0], 3'b000} +: 8] <= char_in;
                end
                field_cnt <= field_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_credential_collector.sv
// tb/tb_credential_collector.sv - randomized self-checking bench for credential_collector
module tb_credential_collector;

    localparam int MAX_FAILS   = 3;
    localparam int LOCK_CYCLES = 16;
`ifdef CREDENTIAL_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [63:0] username;
    logic [63:0] password;
    logic        check;
    logic        match_in = 1'b0;
    logic        granted;
    logic        denied;
    logic        overflow;
    logic        locked;

    credential_collector #(
        .MAX_FAILS   (MAX_FAILS),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .username   (username),
        .password   (password),
        .check      (check),
        .match_in   (match_in),
        .granted    (granted),
        .denied     (denied),
        .overflow   (overflow),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int fails = 0;
    int ever_locked = 0;

    logic [7:0] ubuf [16];
    logic [7:0] pbuf [16];
    int ulen = 0;
    int plen = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_fields(input string u, input string p);
        ulen = u.len();
        plen = p.len();
        for (int i = 0; i < ulen; i++) ubuf[i] = u[i];
        for (int i = 0; i < plen; i++) pbuf[i] = p[i];
    endtask

    task automatic random_fields();
        ulen = $urandom_range(0, 11);
        plen = $urandom_range(0, 11);
        for (int i = 0; i < ulen; i++) ubuf[i] = 8'($urandom_range(1, 255));
        for (int i = 0; i < plen; i++) pbuf[i] = 8'($urandom_range(1, 255));
    endtask

    task automatic send_char(input logic [7:0] c);
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
            char_valid = 1'b0;
            char_in    = 8'($urandom);
            check_eq("ready_idle", char_ready, 1);
            @(negedge clk);
        end
        char_valid = 1'b1;
        char_in    = c;
        check_eq("ready_xfer", char_ready, 1);
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        char_valid = 1'b0;
        match_in   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_pulse", {granted, denied}, 0);
        end
        rst_n = 1'b1;
        fails = 0;
        check_eq("rst_username", username, 0);
        check_eq("rst_password", password, 0);
        check_eq("rst_check", check, 0);
        check_eq("rst_granted", granted, 0);
        check_eq("rst_denied", denied, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_ready", char_ready, 1);
    endtask

    task automatic run_attempt(input bit m);
        logic [63:0] eu;
        logic [63:0] ep;
        bit ovf;
        bit grant;
        int lock_n;
        eu = 64'd0;
        ep = 64'd0;
        for (int i = 0; i < ulen && i < 8; i++) eu[i*8 +: 8] = ubuf[i];
        for (int i = 0; i < plen && i < 8; i++) ep[i*8 +: 8] = pbuf[i];
        ovf   = (ulen > 8) || (plen > 8);
        grant = m && !ovf;

        for (int i = 0; i < ulen; i++) send_char(ubuf[i]);
        send_char(8'h00);
        for (int i = 0; i < plen; i++) send_char(pbuf[i]);
        send_char(8'h00);

        check_eq("check_high", check, 1);
        check_eq("check_ready", char_ready, 0);
        check_eq("check_username", username, eu);
        check_eq("check_password", password, ep);
        check_eq("check_overflow", overflow, 64'(ovf));
        check_eq("check_nopulse", {granted, denied}, 0);
        match_in = m;
        @(negedge clk);

        check_eq("result_granted", granted, 64'(grant));
        check_eq("result_denied", denied, 64'(!grant));
        check_eq("result_check", check, 0);
        check_eq("result_ready", char_ready, 0);
        match_in = 1'($urandom);

        if (grant) fails = 0;
        else fails = (fails >= 15) ? 15 : fails + 1;
        lock_n = 0;
        if (LOCKOUT && !grant && fails == MAX_FAILS) begin
            lock_n = LOCK_CYCLES;
            fails  = 0;
        end
        @(negedge clk);

        for (int i = 0; i < lock_n; i++) begin
            check_eq("lock_level", locked, 1);
            check_eq("lock_ready", char_ready, 0);
            check_eq("lock_nopulse", {granted, denied, check}, 0);
            ever_locked++;
            @(negedge clk);
        end
        check_eq("after_locked", locked, 0);
        check_eq("after_ready", char_ready, 1);
        check_eq("after_username", username, 0);
        check_eq("after_password", password, 0);
        check_eq("after_overflow", overflow, 0);
        match_in = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int locks_before;
        do_reset();

        load_fields("bob", "pw1");
        run_attempt(1'b1);

        do_reset();
        for (int a = 0; a < 3; a++) begin
            load_fields("eve", "bad");
            run_attempt(1'b0);
        end

        do_reset();
        load_fields("abcdefghij", "x");
        run_attempt(1'b1);

        load_fields("", "");
        run_attempt(1'b1);

        load_fields("ab", "");
        for (int i = 0; i < ulen; i++) send_char(ubuf[i]);
        send_char(8'h00);
        send_char(8'h70);
        send_char(8'h71);
        do_reset();
        load_fields("ok", "go");
        run_attempt(1'b1);

        do_reset();
        locks_before = ever_locked;
        load_fields("u", "p");
        run_attempt(1'b0);
        run_attempt(1'b0);
        run_attempt(1'b1);
        run_attempt(1'b0);
        run_attempt(1'b0);
        check_eq("no_lock_seq", 64'(ever_locked - locks_before), 0);

        for (int a = 0; a < 40; a++) begin
            random_fields();
            run_attempt(1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
